// File: rtl/team_10_wb_arbiter_if.sv
// Wishbone bus bundle for the two-master arbiter: both master ports, the shared slave port and grant status.
// slave = the arbiter's own view; master = the surrounding system (both masters plus the slave device).
interface team_10_wb_arbiter_if;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic [1:0]  gnt_o;
  logic        busy_o;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    input  s_ack_i, s_dat_i,
    output m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output gnt_o, busy_o
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    output s_ack_i, s_dat_i,
    input  m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  gnt_o, busy_o
  );
endinterface

// File: rtl/team_10_wb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter with cycle-long ownership and an ack timeout
// that turns a stalled transfer into a one-cycle error pulse to the owning master.
module team_10_wb_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                  clk_i,
  input  logic                  nrst_i,
  team_10_wb_arbiter_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, OWN0, OWN1, ERR0, ERR1} state_t;

  state_t           state_reg, state_next;
  logic             last_gnt_reg, last_gnt_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             req0, req1, stalled, timeout_hit;

  assign req0 = bus.m0_cyc_i & bus.m0_stb_i;
  assign req1 = bus.m1_cyc_i & bus.m1_stb_i;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_reg    <= IDLE;
      last_gnt_reg <= 1'b1;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
      cnt_reg      <= cnt_next;
    end
  end

  // Bus outputs depend only on state, so an asynchronous reset drops the slave cycle at once.
  always_comb begin
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_sel_o  = '0;
    bus.s_adr_o  = '0;
    bus.s_dat_o  = '0;
    bus.m0_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m0_dat_o = '0;
    bus.m1_ack_o = 1'b0;
    bus.m1_err_o = 1'b0;
    bus.m1_dat_o = '0;
    bus.gnt_o    = 2'b00;
    case (state_reg)
      OWN0: begin
        bus.s_cyc_o  = bus.m0_cyc_i;
        bus.s_stb_o  = req0;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.m0_ack_o = bus.s_ack_i & req0;
        bus.m0_dat_o = bus.s_dat_i;
        bus.gnt_o    = 2'b01;
      end
      OWN1: begin
        bus.s_cyc_o  = bus.m1_cyc_i;
        bus.s_stb_o  = req1;
        bus.s_we_o   = bus.m1_we_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.m1_ack_o = bus.s_ack_i & req1;
        bus.m1_dat_o = bus.s_dat_i;
        bus.gnt_o    = 2'b10;
      end
      ERR0: begin
        bus.m0_err_o = 1'b1;
        bus.gnt_o    = 2'b01;
      end
      ERR1: begin
        bus.m1_err_o = 1'b1;
        bus.gnt_o    = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.busy_o  = |bus.gnt_o;
  assign stalled     = bus.s_stb_o & ~bus.s_ack_i;
  assign timeout_hit = (TIMEOUT != 0) && stalled && (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    cnt_next      = '0;
    case (state_reg)
      IDLE: begin
        if (req0 && (!req1 || last_gnt_reg)) state_next = OWN0;
        else if (req1)                      state_next = OWN1;
      end
      OWN0: begin
        if (!bus.m0_cyc_i)    state_next = req1 ? OWN1 : IDLE;
        else if (timeout_hit) state_next = ERR0;
      end
      OWN1: begin
        if (!bus.m1_cyc_i)    state_next = req0 ? OWN0 : IDLE;
        else if (timeout_hit) state_next = ERR1;
      end
      // The errored master is not allowed to win again straight away.
      ERR0:    state_next = req1 ? OWN1 : IDLE;
      ERR1:    state_next = req0 ? OWN0 : IDLE;
      default: state_next = IDLE;
    endcase

    if (state_next == OWN0 && state_reg != OWN0) last_gnt_next = 1'b0;
    if (state_next == OWN1 && state_reg != OWN1) last_gnt_next = 1'b1;

    if (TIMEOUT != 0 && stalled && state_next == state_reg)
      cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
  end
endmodule

// File: tb/tb_team_10_wb_arbiter.sv
// Bench for team_10_wb_arbiter: directed table and sequences, then random traffic against
// an owner/stall-count model of the arbitration rules.
module tb_team_10_wb_arbiter;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  team_10_wb_arbiter_if bus ();
  team_10_wb_arbiter_if bus_z ();

  team_10_wb_arbiter #(.TIMEOUT(TO), .CNT_W(5)) dut   (.clk_i(clk), .nrst_i(nrst), .bus(bus));
  team_10_wb_arbiter #(.TIMEOUT(0),  .CNT_W(5)) dut_z (.clk_i(clk), .nrst_i(nrst), .bus(bus_z));

  // The no-timeout instance sees exactly the same stimulus.
  assign bus_z.m0_cyc_i = bus.m0_cyc_i;
  assign bus_z.m0_stb_i = bus.m0_stb_i;
  assign bus_z.m0_we_i  = bus.m0_we_i;
  assign bus_z.m0_sel_i = bus.m0_sel_i;
  assign bus_z.m0_adr_i = bus.m0_adr_i;
  assign bus_z.m0_dat_i = bus.m0_dat_i;
  assign bus_z.m1_cyc_i = bus.m1_cyc_i;
  assign bus_z.m1_stb_i = bus.m1_stb_i;
  assign bus_z.m1_we_i  = bus.m1_we_i;
  assign bus_z.m1_sel_i = bus.m1_sel_i;
  assign bus_z.m1_adr_i = bus.m1_adr_i;
  assign bus_z.m1_dat_i = bus.m1_dat_i;
  assign bus_z.s_ack_i  = bus.s_ack_i;
  assign bus_z.s_dat_i  = bus.s_dat_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef logic [141:0] outv_t;

  task automatic chk_vec(string name, outv_t act, outv_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic outv_t pack_dut();
    return {bus.gnt_o, bus.busy_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o,
            bus.s_adr_o, bus.s_dat_o, bus.m0_ack_o, bus.m0_err_o, bus.m0_dat_o,
            bus.m1_ack_o, bus.m1_err_o, bus.m1_dat_o};
  endfunction

  // Model: who owns the bus, whether it is in its error cycle, consecutive stalled strobes.
  typedef struct {
    int owner;
    int last;
    int stall;
    bit err;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t grant(mdl_t m, int g);
    mdl_t n = m;
    n.owner = g;
    n.last  = g;
    n.err   = 1'b0;
    n.stall = 0;
    return n;
  endfunction

  function automatic mdl_t model_next(mdl_t m);
    mdl_t n = m;
    bit req0 = bus.m0_cyc_i & bus.m0_stb_i;
    bit req1 = bus.m1_cyc_i & bus.m1_stb_i;
    bit own_cyc, own_req, oth_req;
    own_cyc = (m.owner == 0) ? bus.m0_cyc_i : bus.m1_cyc_i;
    own_req = (m.owner == 0) ? req0 : req1;
    oth_req = (m.owner == 0) ? req1 : req0;
    if (m.owner < 0) begin
      if (req0 && req1) n = grant(m, 1 - m.last);
      else if (req0)    n = grant(m, 0);
      else if (req1)    n = grant(m, 1);
    end else if (m.err || !own_cyc) begin
      if (oth_req) n = grant(m, 1 - m.owner);
      else begin
        n.owner = -1;
        n.err   = 1'b0;
        n.stall = 0;
      end
    end else begin
      n.stall = (own_req && !bus.s_ack_i) ? m.stall + 1 : 0;
      if (TO > 0 && n.stall >= TO) begin
        n.err   = 1'b1;
        n.stall = 0;
      end
    end
    return n;
  endfunction

  function automatic outv_t model_out(mdl_t m);
    logic [1:0]  gnt = 2'b00;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, wd = '0, d0 = '0, d1 = '0;
    logic        a0 = 1'b0, e0 = 1'b0, a1 = 1'b0, e1 = 1'b0;
    if (m.owner >= 0) begin
      gnt = (m.owner == 0) ? 2'b01 : 2'b10;
      if (m.err) begin
        if (m.owner == 0) e0 = 1'b1; else e1 = 1'b1;
      end else if (m.owner == 0) begin
        cyc = bus.m0_cyc_i; stb = bus.m0_cyc_i & bus.m0_stb_i; we = bus.m0_we_i;
        sel = bus.m0_sel_i; adr = bus.m0_adr_i; wd = bus.m0_dat_i;
        a0 = stb & bus.s_ack_i; d0 = bus.s_dat_i;
      end else begin
        cyc = bus.m1_cyc_i; stb = bus.m1_cyc_i & bus.m1_stb_i; we = bus.m1_we_i;
        sel = bus.m1_sel_i; adr = bus.m1_adr_i; wd = bus.m1_dat_i;
        a1 = stb & bus.s_ack_i; d1 = bus.s_dat_i;
      end
    end
    return {gnt, |gnt, cyc, stb, we, sel, adr, wd, a0, e0, d0, a1, e1, d1};
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) mdl <= '{owner: -1, last: 1, stall: 0, err: 1'b0};
    else       mdl <= model_next(mdl);
  end

  typedef struct {
    bit [4:0]   in;   // {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}
    logic [1:0] gnt;
    bit [4:0]   out;  // {s_stb, m0_ack, m1_ack, m0_err, m1_err}
  } vec_t;

  function automatic vec_t row(bit [4:0] in, logic [1:0] gnt, bit [4:0] out);
    vec_t v;
    v.in = in; v.gnt = gnt; v.out = out;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; bus.m0_sel_i = '0;
    bus.m0_adr_i = '0; bus.m0_dat_i = '0;
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.m1_sel_i = '0;
    bus.m1_adr_i = '0; bus.m1_dat_i = '0;
    bus.s_ack_i  = 0; bus.s_dat_i  = '0;
  endtask

  task automatic rand_inputs(int ack_pct);
    if (bus.m0_cyc_i) begin
      if ($urandom_range(0, 31) == 0) bus.m0_cyc_i = 1'b0;
    end else if ($urandom_range(0, 3) == 0) bus.m0_cyc_i = 1'b1;
    if (bus.m1_cyc_i) begin
      if ($urandom_range(0, 31) == 0) bus.m1_cyc_i = 1'b0;
    end else if ($urandom_range(0, 3) == 0) bus.m1_cyc_i = 1'b1;
    bus.m0_stb_i = ($urandom_range(0, 7) != 0);
    bus.m1_stb_i = ($urandom_range(0, 7) != 0);
    bus.m0_we_i  = 1'($urandom());
    bus.m1_we_i  = 1'($urandom());
    bus.m0_sel_i = 4'($urandom());
    bus.m1_sel_i = 4'($urandom());
    bus.m0_adr_i = $urandom();
    bus.m1_adr_i = $urandom();
    bus.m0_dat_i = $urandom();
    bus.m1_dat_i = $urandom();
    bus.s_dat_i  = $urandom();
    bus.s_ack_i  = ($urandom_range(0, 99) < ack_pct);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[19];
  int   n_stb, n_err, n_stb_z, n_err_z, n_ack, ack_pct;
  bit   got;

  initial begin
    tbl[0]  = row(5'b11110, 2'b00, 5'b00000);  // tie seen in IDLE
    tbl[1]  = row(5'b11110, 2'b01, 5'b10000);  // m0 wins first tie
    tbl[2]  = row(5'b11111, 2'b01, 5'b11000);
    tbl[3]  = row(5'b00110, 2'b01, 5'b00000);  // m0 releases, m1 pending
    tbl[4]  = row(5'b00110, 2'b10, 5'b10000);  // handoff without bubble
    tbl[5]  = row(5'b00111, 2'b10, 5'b10100);
    tbl[6]  = row(5'b00000, 2'b10, 5'b00000);
    tbl[7]  = row(5'b11110, 2'b00, 5'b00000);
    tbl[8]  = row(5'b11110, 2'b01, 5'b10000);  // round-robin back to m0
    tbl[9]  = row(5'b00000, 2'b01, 5'b00000);
    tbl[10] = row(5'b11000, 2'b00, 5'b00000);
    tbl[11] = row(5'b11000, 2'b01, 5'b10000);
    tbl[12] = row(5'b11000, 2'b01, 5'b10000);
    tbl[13] = row(5'b00000, 2'b01, 5'b00000);  // abort before ack
    tbl[14] = row(5'b00001, 2'b00, 5'b00000);  // late ack ignored
    tbl[15] = row(5'b11110, 2'b00, 5'b00000);
    tbl[16] = row(5'b11110, 2'b10, 5'b10000);  // m0 was last, m1 wins
    tbl[17] = row(5'b00000, 2'b10, 5'b00000);
    tbl[18] = row(5'b00000, 2'b00, 5'b00000);

    idle_inputs();
    nrst = 1'b0;
    #1;
    chk("reset_outputs", 32'(pack_dut() != '0), 32'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      {bus.m0_cyc_i, bus.m0_stb_i, bus.m1_cyc_i, bus.m1_stb_i, bus.s_ack_i} = tbl[i].in;
      #1;
      chk($sformatf("table_row%0d", i),
          32'({bus.gnt_o, bus.busy_o, bus.s_stb_o, bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}),
          32'({tbl[i].gnt, |tbl[i].gnt, tbl[i].out}));
    end
    $display("table: %0d rows applied", 19);

    // Single-master write, slave acks on the third strobe cycle.
    @(negedge clk);
    idle_inputs();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 1; bus.m0_sel_i = 4'hF;
    bus.m0_adr_i = 32'h3000_0004; bus.m0_dat_i = 32'hA5A5_0001;
    #1;
    chk("wr_idle_gnt", 32'(bus.gnt_o), 32'd0);
    n_ack = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.s_ack_i = (c == 3);
      #1;
      chk("wr_adr", bus.s_adr_o, 32'h3000_0004);
      chk("wr_dat", bus.s_dat_o, 32'hA5A5_0001);
      chk("wr_we_sel", 32'({bus.s_we_o, bus.s_sel_o}), 32'h1F);
      chk("wr_m1_ack", 32'(bus.m1_ack_o), 32'd0);
      n_ack += int'(bus.m0_ack_o);
    end
    chk("wr_ack_on_third", 32'(bus.m0_ack_o), 32'd1);
    @(negedge clk);
    bus.s_ack_i = 0; bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    #1;
    chk("wr_release_stb", 32'({bus.s_cyc_o, bus.s_stb_o, bus.m0_ack_o}), 32'd0);
    chk("wr_ack_count", 32'(n_ack), 32'd1);
    @(negedge clk);
    #1;
    chk("wr_back_idle", 32'(bus.gnt_o), 32'd0);
    $display("write: adr=0x30000004 dat=0xa5a50001 acks=%0d", n_ack);

    // Read by m1.
    @(negedge clk);
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 0; bus.m1_adr_i = 32'h3000_0008;
    #1;
    chk("rd_idle_gnt", 32'(bus.gnt_o), 32'd0);
    @(negedge clk);
    bus.s_dat_i = 32'hDEAD_BEEF; bus.s_ack_i = 1;
    #1;
    chk("rd_m1_dat", bus.m1_dat_o, 32'hDEAD_BEEF);
    chk("rd_m1_ack", 32'(bus.m1_ack_o), 32'd1);
    chk("rd_m0_dat", bus.m0_dat_o, 32'd0);
    chk("rd_m0_ack", 32'(bus.m0_ack_o), 32'd0);
    chk("rd_adr", bus.s_adr_o, 32'h3000_0008);
    @(negedge clk);
    bus.s_ack_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
    #1;
    chk("rd_release_m0_dat", bus.m0_dat_o, 32'd0);
    @(negedge clk);
    bus.s_dat_i = '0;
    $display("read: m1 got 0x%08h", 32'hDEAD_BEEF);

    // Timeout with m1 waiting.
    @(negedge clk);
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    #1;
    n_stb = 0;
    got   = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
      #1;
      if (bus.s_stb_o) n_stb++;
      else got = 1;
    end
    chk("to_reached", 32'(got), 32'd1);
    chk("to_stb_cycles", 32'(n_stb), 32'(TO));
    chk("to_err_cycle", 32'({bus.m0_err_o, bus.m0_ack_o, bus.s_cyc_o, bus.m1_err_o, bus.gnt_o}), 32'b10_0001);
    @(negedge clk);
    #1;
    chk("to_handoff_m1", 32'({bus.gnt_o, bus.s_stb_o, bus.m0_err_o}), 32'b1010);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    $display("timeout: %0d strobe cycles then err", n_stb);

    // Asynchronous reset in the middle of an m0 transfer.
    @(negedge clk);
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    @(negedge clk);
    #1;
    chk("rst_pre_stb", 32'(bus.s_stb_o), 32'd1);
    bus.s_ack_i = 1;
    nrst = 1'b0;
    #1;
    chk("rst_async", 32'({bus.s_cyc_o, bus.s_stb_o, bus.gnt_o, bus.busy_o, bus.m0_ack_o, bus.m1_ack_o}), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    idle_inputs();
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
    #1;
    chk("rst_after_idle", 32'(bus.gnt_o), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_m1_grant", 32'(bus.gnt_o), 32'b10);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    $display("reset: mid-transfer reset cleared the bus");

    // Continuous stall: TIMEOUT=0 never errors, TIMEOUT=16 keeps re-arbitrating.
    @(negedge clk);
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    #1;
    n_stb_z = 0; n_err_z = 0; n_err = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      n_stb_z += int'(bus_z.s_stb_o);
      n_err_z += int'(bus_z.m0_err_o);
      n_err   += int'(bus.m0_err_o);
    end
    chk("t0_no_err", 32'(n_err_z), 32'd0);
    chk("t0_stb_held", 32'(n_stb_z), 32'd100);
    chk("t16_err_pulses", 32'(n_err), 32'd5);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    $display("stall: timeout=0 errs=%0d, timeout=16 errs=%0d", n_err_z, n_err);

    // Random traffic against the model.
    ack_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 150 == 0) begin
        case ($urandom_range(0, 2))
          0:       ack_pct = 0;
          1:       ack_pct = 15;
          default: ack_pct = 60;
        endcase
      end
      rand_inputs(ack_pct);
      #1;
      chk_vec("random_cycle", pack_dut(), model_out(mdl));
    end
    $display("random: 3000 cycles compared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
